// File: rtl/sym_dn_lut_loader.sv
// Write-side sequencer for the symmetric decision-node LUT: unpacks a stream of
// packed 2-bit entries into per-entry bank/address writes, one entry per write_clk.
module sym_dn_lut_loader #(
    parameter int IN_W    = 16,
    parameter int PAGE_AW = 6
) (
    input  logic               write_clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [IN_W-1:0]    in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               lut_in_bank0,
    output logic               lut_in_bank1,
    output logic [PAGE_AW-1:0] page_write_addr,
    output logic               write_addr_offset,
    output logic               we,
    output logic               busy,
    output logic               done
);

    localparam int SLOTS  = IN_W / 2;
    localparam int SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int EW     = PAGE_AW + 1;

    localparam logic [SLOT_W-1:0] LAST_SLOT  = SLOT_W'(SLOTS - 1);
    localparam logic [EW-1:0]     LAST_ENTRY = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE,
        S_DONE
    } state_t;

    state_t            r_state;
    logic [IN_W-1:0]   r_shreg;
    logic [EW-1:0]     r_entry;
    logic [SLOT_W-1:0] r_slot;

    logic w_last_slot;
    logic w_final_entry;

    assign w_last_slot   = (r_slot == LAST_SLOT);
    assign w_final_entry = (r_entry == LAST_ENTRY);

    // Every output is a decode of registered state, so nothing combinational
    // reaches the LUT or the upstream source from this block's inputs.
    assign in_ready          = (r_state == S_LOAD) ||
                               ((r_state == S_WRITE) && w_last_slot && !w_final_entry);
    assign we                = (r_state == S_WRITE);
    assign busy              = (r_state != S_IDLE);
    assign done              = (r_state == S_DONE);
    assign lut_in_bank0      = r_shreg[0];
    assign lut_in_bank1      = r_shreg[1];
    assign page_write_addr   = r_entry[PAGE_AW:1];
    assign write_addr_offset = r_entry[0];

    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order within the block.
    always_ff @(posedge write_clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_shreg <= '0;
            r_entry <= '0;
            r_slot  <= '0;
        end else if (abort && (r_state != S_IDLE)) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_entry <= '0;
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (in_valid) begin
                        r_shreg <= in_data;
                        r_slot  <= '0;
                        r_state <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    r_shreg <= r_shreg >> 2;
                    r_slot  <= r_slot + SLOT_W'(1);
                    // Hold at the last entry so the address never wraps.
                    if (!w_final_entry) begin
                        r_entry <= r_entry + EW'(1);
                    end
                    if (w_last_slot) begin
                        if (w_final_entry) begin
                            r_state <= S_DONE;
                        end else if (in_valid) begin
                            r_shreg <= in_data;
                            r_slot  <= '0;
                        end else begin
                            r_state <= S_LOAD;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sym_dn_lut_loader.sv
// Self-checking bench for sym_dn_lut_loader: a table of load scenarios plus
// hand-written reset sequences, checking write order, data and timing.
module tb_sym_dn_lut_loader;

    localparam int IN_W    = 16;
    localparam int PAGE_AW = 6;
    localparam int SLOTS   = IN_W / 2;
    localparam int ENTRIES = 2 ** (PAGE_AW + 1);
    localparam int WORDS   = ENTRIES / SLOTS;

    logic               write_clk = 1'b0;
    logic               rst;
    logic               start;
    logic               abort;
    logic [IN_W-1:0]    in_data;
    logic               in_valid;
    logic               in_ready;
    logic               lut_in_bank0;
    logic               lut_in_bank1;
    logic [PAGE_AW-1:0] page_write_addr;
    logic               write_addr_offset;
    logic               we;
    logic               busy;
    logic               done;

    int checks = 0;
    int errors = 0;

    logic [IN_W-1:0] words [WORDS];

    sym_dn_lut_loader #(.IN_W(IN_W), .PAGE_AW(PAGE_AW)) dut (
        .write_clk         (write_clk),
        .rst               (rst),
        .start             (start),
        .abort             (abort),
        .in_data           (in_data),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .lut_in_bank0      (lut_in_bank0),
        .lut_in_bank1      (lut_in_bank1),
        .page_write_addr   (page_write_addr),
        .write_addr_offset (write_addr_offset),
        .we                (we),
        .busy              (busy),
        .done              (done)
    );

    always #5 write_clk = ~write_clk;

    // gap: idle cycles the source inserts while the loader is asking for a word.
    // *_at: write count (-1 = unused) at which abort/start/rst is driven.
    typedef struct {
        int gap;
        int abort_at;
        int start_at;
        int rst_at;
        int exp_writes;
        int exp_done;
        int exp_done_cyc;
        int exp_loads;
    } scen_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [12:0] outs();
        return {in_ready, we, lut_in_bank1, lut_in_bank0, page_write_addr,
                write_addr_offset, busy, done};
    endfunction

    task automatic run_scen(input scen_t s);
        int widx = 0, gap_ctr = 0, exp_e = 0, writes = 0;
        int dones = 0, done_cyc = -1, first_we = -1, loads = 0;
        bit post_abort = 0, post_rst = 0, post_done = 0, fin = 0;
        logic [IN_W-1:0] w;
        logic [1:0]      exp_bank;

        @(negedge write_clk);
        start    = 1'b1;
        abort    = 1'b0;
        in_valid = 1'b0;
        for (int cyc = 1; cyc < 600 && !fin; cyc++) begin
            @(negedge write_clk);
            start = 1'b0;
            abort = 1'b0;
            if (post_abort) begin
                in_valid = 1'b0;
                check("abort_we",   64'(we),   64'(0));
                check("abort_busy", 64'(busy), 64'(0));
                check("abort_done", 64'(done), 64'(0));
                fin = 1;
            end else if (post_rst) begin
                in_valid = 1'b0;
                check("rst_outputs", 64'(outs()), 64'(0));
                rst = 1'b0;
                fin = 1;
            end else if (post_done) begin
                in_valid = 1'b0;
                check("idle_after_done", 64'({busy, done}), 64'(0));
                fin = 1;
            end else begin
                if (we) begin
                    if (writes == 0) first_we = cyc;
                    if (exp_e < ENTRIES) begin
                        w        = words[exp_e / SLOTS];
                        exp_bank = 2'(w >> (2 * (exp_e % SLOTS)));
                        check("write_addr_data",
                              64'({page_write_addr, write_addr_offset, lut_in_bank1, lut_in_bank0}),
                              64'({6'(exp_e >> 1), 1'(exp_e & 1), exp_bank}));
                    end else begin
                        check("extra_write", 64'(exp_e), 64'(ENTRIES - 1));
                    end
                    exp_e++;
                    writes++;
                end
                if (busy && in_ready && !we) loads++;
                if (done) begin
                    dones++;
                    done_cyc  = cyc;
                    post_done = 1;
                    if (s.start_at >= 0) start = 1'b1;
                end
                if (we && s.abort_at >= 0 && writes == s.abort_at) begin
                    abort      = 1'b1;
                    post_abort = 1;
                end
                if (we && s.rst_at >= 0 && writes == s.rst_at) begin
                    rst      = 1'b1;
                    post_rst = 1;
                end
                if (we && s.start_at >= 0 && writes == s.start_at) start = 1'b1;

                in_valid = (widx < WORDS) && (gap_ctr == 0);
                in_data  = (widx < WORDS) ? words[widx] : '0;
                if (in_valid && in_ready) begin
                    widx++;
                    gap_ctr = s.gap;
                end else if (!in_valid && in_ready && gap_ctr > 0) begin
                    gap_ctr--;
                end
            end
        end
        in_valid = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        if (!fin) check("timeout", 64'(1), 64'(0));
        check("write_count", 64'(writes), 64'(s.exp_writes));
        check("done_count",  64'(dones),  64'(s.exp_done));
        if (s.exp_writes > 0)    check("first_we_cycle", 64'(first_we), 64'(2));
        if (s.exp_done_cyc >= 0) check("done_cycle",     64'(done_cyc), 64'(s.exp_done_cyc));
        if (s.exp_loads >= 0)    check("load_cycles",    64'(loads),    64'(s.exp_loads));
    endtask

    initial begin
        scen_t scens [6];
        // Throttled: each of 15 later words waits 3 cycles -> done 130 + 45.
        scens[0] = '{gap: 0, abort_at: -1, start_at: -1, rst_at: -1,
                     exp_writes: 128, exp_done: 1, exp_done_cyc: 130, exp_loads: 1};
        scens[1] = '{gap: 3, abort_at: -1, start_at: -1, rst_at: -1,
                     exp_writes: 128, exp_done: 1, exp_done_cyc: 175, exp_loads: 46};
        scens[2] = '{gap: 0, abort_at: 40, start_at: -1, rst_at: -1,
                     exp_writes: 40, exp_done: 0, exp_done_cyc: -1, exp_loads: -1};
        scens[3] = '{gap: 0, abort_at: -1, start_at: 60, rst_at: -1,
                     exp_writes: 128, exp_done: 1, exp_done_cyc: 130, exp_loads: 1};
        scens[4] = '{gap: 0, abort_at: -1, start_at: -1, rst_at: 78,
                     exp_writes: 78, exp_done: 0, exp_done_cyc: -1, exp_loads: -1};
        scens[5] = '{gap: 0, abort_at: -1, start_at: -1, rst_at: -1,
                     exp_writes: 128, exp_done: 1, exp_done_cyc: 130, exp_loads: 1};

        for (int k = 0; k < WORDS; k++) words[k] = 16'(k * 16'h1B1B);

        rst      = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (2) @(negedge write_clk);
        check("reset_outputs", 64'(outs()), 64'(0));
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge write_clk);
            check("idle_outputs", 64'(outs()), 64'(0));
        end

        // Stray valid while idle must not be consumed or start anything.
        in_valid = 1'b1;
        in_data  = 16'hFFFF;
        @(negedge write_clk);
        check("idle_ignores_valid", 64'({in_ready, busy, we}), 64'(0));
        in_valid = 1'b0;

        for (int i = 0; i < 6; i++) run_scen(scens[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
